// File: rtl/noise_sweep_ctrl.sv
// Button-driven display-mode select and automatic AWGN noise sweep with Costas lock qualification.
// Define NOISE_SWEEP_STATS_EN to build the acquisition-time and lock-loss statistics registers.
module noise_sweep_ctrl #(
    parameter int DEBOUNCE_CYCLES   = 270000,
    parameter int LONG_PRESS_CYCLES = 27000000,
    parameter int ACQ_TIMEOUT       = 80000,
    parameter int DWELL_CYCLES      = 262144,
    parameter int NOISE_W           = 8,
    parameter int NOISE_STEP        = 8,
    parameter int NOISE_MAX         = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_n_i,
    input  logic               pll_locked_i,
    input  logic               costas_lock_i,
    output logic [1:0]         display_mode_o,
    output logic [NOISE_W-1:0] noise_mag_o,
    output logic               noise_upd_o,
    output logic               sweep_active_o,
    output logic               sweep_done_o,
    output logic               sweep_pass_o,
    output logic [NOISE_W-1:0] max_noise_locked_o,
    output logic [31:0]        acq_cycles_o,
    output logic [15:0]        lock_loss_cnt_o
);

    // state   | meaning
    // IDLE    | no sweep, noise held at 0
    // ACQUIRE | waiting for Costas lock at the current noise level
    // DWELL   | lock must hold continuously for the dwell window
    // STEP    | level passed, raise noise or finish
    // DONE    | results held until restart or PLL loss
    typedef enum logic [2:0] {S_IDLE, S_ACQUIRE, S_DWELL, S_STEP, S_DONE} state_t;

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LP_W    = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int TMR_MAX = (ACQ_TIMEOUT > DWELL_CYCLES) ? ACQ_TIMEOUT : DWELL_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LP_W-1:0]    LP_LAST    = LP_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [TMR_W-1:0]   ACQ_LAST   = TMR_W'(ACQ_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]   DWELL_LAST = TMR_W'(DWELL_CYCLES - 1);
    localparam logic [NOISE_W:0]   STEP_EXT   = (NOISE_W + 1)'(NOISE_STEP);
    localparam logic [NOISE_W:0]   MAX_EXT    = (NOISE_W + 1)'(NOISE_MAX);

    logic              btn_meta_q, btn_sync_q;
    logic              db_pressed_q, db_pressed_d, db_prev_q;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [LP_W-1:0]   press_cnt_q, press_cnt_d;
    logic              long_done_q, long_done_d;
    logic              long_evt, short_evt;
    logic [1:0]        mode_q, mode_d;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [NOISE_W-1:0] noise_q, noise_d, max_q, max_d;
    logic              upd_q, upd_d, pass_q, pass_d;
    logic [NOISE_W:0]  noise_sum;
    logic              sweep_start, abort;

    always_comb begin
        db_pressed_d = db_pressed_q;
        db_cnt_d     = '0;
        if (~btn_sync_q != db_pressed_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_pressed_d = ~db_pressed_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        // long_done marks a press already consumed as long, so its release is silent
        press_cnt_d = '0;
        long_done_d = 1'b0;
        long_evt    = 1'b0;
        if (db_pressed_q) begin
            press_cnt_d = press_cnt_q;
            long_done_d = long_done_q;
            if (!long_done_q) begin
                if (press_cnt_q == LP_LAST) begin
                    long_evt    = 1'b1;
                    long_done_d = 1'b1;
                end else begin
                    press_cnt_d = press_cnt_q + 1'b1;
                end
            end
        end
        short_evt = db_prev_q & ~db_pressed_q & ~long_done_q;
        mode_d    = short_evt ? mode_q + 2'd1 : mode_q;
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        noise_d     = noise_q;
        max_d       = max_q;
        pass_d      = pass_q;
        upd_d       = 1'b0;
        sweep_start = 1'b0;
        abort       = 1'b0;
        noise_sum   = {1'b0, noise_q} + STEP_EXT;

        if (state_q != S_IDLE && !pll_locked_i) begin
            state_d = S_IDLE;
            timer_d = '0;
            noise_d = '0;
            max_d   = '0;
            pass_d  = 1'b0;
            upd_d   = (noise_q != '0);
        end else begin
            unique case (state_q)
                S_IDLE:  sweep_start = long_evt & pll_locked_i;
                S_DONE:  sweep_start = long_evt;
                S_ACQUIRE: begin
                    if (long_evt) begin
                        abort = 1'b1;
                    end else if (costas_lock_i) begin
                        state_d = S_DWELL;
                        timer_d = '0;
                    end else if (timer_q == ACQ_LAST) begin
                        state_d = S_DONE;
                        pass_d  = 1'b0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_DWELL: begin
                    if (long_evt) begin
                        abort = 1'b1;
                    end else if (!costas_lock_i) begin
                        state_d = S_DONE;
                        pass_d  = 1'b0;
                    end else if (timer_q == DWELL_LAST) begin
                        max_d   = noise_q;
                        state_d = S_STEP;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_STEP: begin
                    if (long_evt) begin
                        abort = 1'b1;
                    end else if (noise_sum > MAX_EXT) begin
                        state_d = S_DONE;
                        pass_d  = 1'b1;
                    end else begin
                        noise_d = noise_sum[NOISE_W-1:0];
                        upd_d   = 1'b1;
                        timer_d = '0;
                        state_d = S_ACQUIRE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (sweep_start) begin
            state_d = S_ACQUIRE;
            timer_d = '0;
            noise_d = '0;
            max_d   = '0;
            pass_d  = 1'b0;
            upd_d   = (noise_q != '0);
        end
        if (abort) begin
            state_d = S_IDLE;
            timer_d = '0;
            noise_d = '0;
            upd_d   = (noise_q != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta_q   <= 1'b1;
            btn_sync_q   <= 1'b1;
            db_pressed_q <= 1'b0;
            db_prev_q    <= 1'b0;
            db_cnt_q     <= '0;
            press_cnt_q  <= '0;
            long_done_q  <= 1'b0;
            mode_q       <= 2'd0;
            state_q      <= S_IDLE;
            timer_q      <= '0;
            noise_q      <= '0;
            max_q        <= '0;
            pass_q       <= 1'b0;
            upd_q        <= 1'b0;
        end else begin
            btn_meta_q   <= btn_n_i;
            btn_sync_q   <= btn_meta_q;
            db_pressed_q <= db_pressed_d;
            db_prev_q    <= db_pressed_q;
            db_cnt_q     <= db_cnt_d;
            press_cnt_q  <= press_cnt_d;
            long_done_q  <= long_done_d;
            mode_q       <= mode_d;
            state_q      <= state_d;
            timer_q      <= timer_d;
            noise_q      <= noise_d;
            max_q        <= max_d;
            pass_q       <= pass_d;
            upd_q        <= upd_d;
        end
    end

    assign display_mode_o     = mode_q;
    assign noise_mag_o        = noise_q;
    assign noise_upd_o        = upd_q;
    assign sweep_active_o     = (state_q == S_ACQUIRE) || (state_q == S_DWELL) || (state_q == S_STEP);
    assign sweep_done_o       = (state_q == S_DONE);
    assign sweep_pass_o       = pass_q;
    assign max_noise_locked_o = max_q;

`ifdef NOISE_SWEEP_STATS_EN
    logic [31:0] acq_q;
    logic [15:0] loss_q;
    logic        costas_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            acq_q         <= '0;
            loss_q        <= '0;
            costas_prev_q <= 1'b0;
        end else begin
            costas_prev_q <= costas_lock_i;
            if (sweep_start) begin
                acq_q  <= '0;
                loss_q <= '0;
            end else begin
                if (state_q == S_ACQUIRE && state_d == S_DWELL) begin
                    acq_q <= 32'(timer_q);
                end
                if (sweep_active_o && costas_prev_q && !costas_lock_i && loss_q != 16'hFFFF) begin
                    loss_q <= loss_q + 16'd1;
                end
            end
        end
    end

    assign acq_cycles_o    = acq_q;
    assign lock_loss_cnt_o = loss_q;
`else
    assign acq_cycles_o    = 32'd0;
    assign lock_loss_cnt_o = 16'd0;
`endif

endmodule
